// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter for a single-port synchronous data memory.
// Optional owner lock when DMEM_ARB_LOCK_EN is defined.
module dmem_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_GRANT = 4
) (
  input  logic              clk,
  input  logic              reset_n_i,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] m1_rdata_o,
`ifdef DMEM_ARB_LOCK_EN
  input  logic              m0_lock_i,
  input  logic              m1_lock_i,
`endif
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int unsigned CNT_W = $clog2(MAX_GRANT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_GRANT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             rd_vld_q, rd_port_q;
  logic             gnt0, gnt1;
  logic             lock0, lock1;

`ifdef DMEM_ARB_LOCK_EN
  assign lock0 = m0_lock_i;
  assign lock1 = m1_lock_i;
`else
  assign lock0 = 1'b0;
  assign lock1 = 1'b0;
`endif

  assign cnt_inc = (cnt_q < CNT_MAX) ? cnt_q + CNT_ONE : cnt_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_req_i && (!m1_req_i || !ptr_q)) begin
          gnt0    = 1'b1;
          state_d = OWN0;
          cnt_d   = CNT_ONE;
        end else if (m1_req_i) begin
          gnt1    = 1'b1;
          state_d = OWN1;
          cnt_d   = CNT_ONE;
        end
      end
      // A locked owner with no request keeps ownership but issues no beat.
      OWN0: begin
        if (m0_req_i && (lock0 || cnt_q < CNT_MAX || !m1_req_i)) begin
          gnt0  = 1'b1;
          cnt_d = cnt_inc;
        end else if (lock0 && !m0_req_i) begin
          state_d = OWN0;
        end else if (m1_req_i) begin
          gnt1    = 1'b1;
          state_d = OWN1;
          cnt_d   = CNT_ONE;
        end else begin
          state_d = IDLE;
          ptr_d   = 1'b1;
        end
      end
      OWN1: begin
        if (m1_req_i && (lock1 || cnt_q < CNT_MAX || !m0_req_i)) begin
          gnt1  = 1'b1;
          cnt_d = cnt_inc;
        end else if (lock1 && !m1_req_i) begin
          state_d = OWN1;
        end else if (m0_req_i) begin
          gnt0    = 1'b1;
          state_d = OWN0;
          cnt_d   = CNT_ONE;
        end else begin
          state_d = IDLE;
          ptr_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are forced quiet for the whole reset cycle.
    if (!reset_n_i) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      ptr_q     <= 1'b0;
      cnt_q     <= '0;
      rd_vld_q  <= 1'b0;
      rd_port_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      rd_vld_q  <= (gnt0 && !m0_we_i) || (gnt1 && !m1_we_i);
      rd_port_q <= gnt1;
    end
  end

  assign m0_gnt_o    = gnt0;
  assign m1_gnt_o    = gnt1;
  assign mem_en_o    = gnt0 | gnt1;
  assign mem_we_o    = (gnt0 & m0_we_i) | (gnt1 & m1_we_i);
  assign mem_addr_o  = gnt0 ? m0_addr_i  : (gnt1 ? m1_addr_i  : '0);
  assign mem_wdata_o = gnt0 ? m0_wdata_i : (gnt1 ? m1_wdata_i : '0);

  assign m0_rvalid_o = reset_n_i & rd_vld_q & ~rd_port_q;
  assign m1_rvalid_o = reset_n_i & rd_vld_q & rd_port_q;
  assign m0_rdata_o  = mem_rdata_i;
  assign m1_rdata_o  = mem_rdata_i;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter (MAX_GRANT=4) with a small synchronous memory.
// Lock scenario runs only when DMEM_ARB_LOCK_EN is defined.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_lock = 1'b0, m1_lock = 1'b0;
  logic        nx_lock0 = 1'b0, nx_lock1 = 1'b0;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [256];

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic        exp_rv0 = 1'b0, exp_rv1 = 1'b0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_GRANT(4)) dut (
    .clk(clk), .reset_n_i(reset_n),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
`ifdef DMEM_ARB_LOCK_EN
    .m0_lock_i(m0_lock), .m1_lock_i(m1_lock),
`endif
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  // Preload happens while reset is held, so one process owns the array.
  always @(posedge clk) begin
    if (!reset_n) mem[8'h10] <= 32'hCAFEF00D;
    else if (mem_en) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag,
                      input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                      input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                      input logic e0, input logic e1);
    logic [31:0] ea, ed;
    @(negedge clk);
    reset_n = 1'b1;
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    m0_lock = nx_lock0; m1_lock = nx_lock1;
    #1;
    ea = e0 ? a0 : (e1 ? a1 : 32'h0);
    ed = e0 ? d0 : (e1 ? d1 : 32'h0);
    check({tag, "/gnt0"},   64'(m0_gnt),    64'(e0));
    check({tag, "/gnt1"},   64'(m1_gnt),    64'(e1));
    check({tag, "/en"},     64'(mem_en),    64'(e0 | e1));
    check({tag, "/we"},     64'(mem_we),    64'((e0 & w0) | (e1 & w1)));
    check({tag, "/addr"},   64'(mem_addr),  64'(ea));
    check({tag, "/wdata"},  64'(mem_wdata), 64'(ed));
    check({tag, "/rvalid0"}, 64'(m0_rvalid), 64'(exp_rv0));
    check({tag, "/rvalid1"}, 64'(m1_rvalid), 64'(exp_rv1));
    exp_rv0 = e0 & ~w0;
    exp_rv1 = e1 & ~w1;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset_n = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m1_req = 1'b1; m1_we = 1'b1;
    nx_lock0 = 1'b0; nx_lock1 = 1'b0;
    #1;
    check({tag, "/rst_gnt0"}, 64'(m0_gnt),    64'd0);
    check({tag, "/rst_gnt1"}, 64'(m1_gnt),    64'd0);
    check({tag, "/rst_en"},   64'(mem_en),    64'd0);
    check({tag, "/rst_we"},   64'(mem_we),    64'd0);
    check({tag, "/rst_rv0"},  64'(m0_rvalid), 64'd0);
    check({tag, "/rst_rv1"},  64'(m1_rvalid), 64'd0);
    @(negedge clk);
    m0_req = 1'b0; m1_req = 1'b0;
    exp_rv0 = 1'b0; exp_rv1 = 1'b0;
  endtask

  initial begin
    do_reset("init");

    // Single-port read of a preloaded word
    step("t1_rd", 1, 0, 32'h10, 0, 0, 0, 0, 0, 1, 0);
    step("t1_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("t1_rdata", 64'(m0_rdata), 64'h0000_0000_CAFE_F00D);

    // Contention from reset: bursts of four alternate
    do_reset("t2");
    for (int i = 0; i < 12; i++) begin
      logic g1;
      g1 = ((i / 4) % 2) == 1;
      step($sformatf("t2_c%0d", i), 1, 0, 32'h04, 0, 1, 0, 32'h08, 0, !g1, g1);
    end

    // m0 drops out: m1 streams past the burst limit, then m0 reclaims at once
    for (int i = 0; i < 7; i++)
      step($sformatf("t3_m1_%0d", i), 0, 0, 0, 0, 1, 0, 32'h0C, 0, 0, 1);
    step("t3_back", 1, 0, 32'h04, 0, 1, 0, 32'h0C, 0, 1, 0);

    // Write from m0 then read-back from m1
    step("t4_wr", 1, 1, 32'h20, 32'h1234, 0, 0, 0, 0, 1, 0);
    step("t4_rd", 0, 0, 0, 0, 1, 0, 32'h20, 0, 0, 1);
    step("t4_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("t4_rdata", 64'(m1_rdata), 64'h1234);

    // Reset right behind an m1 read discards it and restores port-0 preference
    step("t5_rd", 0, 0, 0, 0, 1, 0, 32'h10, 0, 0, 1);
    do_reset("t5");
    step("t5_both", 1, 0, 32'h04, 0, 1, 0, 32'h08, 0, 1, 0);

`ifdef DMEM_ARB_LOCK_EN
    do_reset("t6");
    step("t6_own", 0, 0, 0, 0, 1, 0, 32'h08, 0, 0, 1);
    nx_lock1 = 1'b1;
    for (int i = 0; i < 8; i++)
      step($sformatf("t6_lk%0d", i), 1, 0, 32'h04, 0, 1, 0, 32'h08, 0, 0, 1);
    step("t6_hold", 1, 0, 32'h04, 0, 0, 0, 0, 0, 0, 0);
    nx_lock1 = 1'b0;
    step("t6_rel", 1, 0, 32'h04, 0, 0, 0, 0, 0, 1, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
